// File: rtl/cpu_wb_bridge.sv
// Host SRAM-style bus to Wishbone initiator bridge.
// Host strobes are synchronised, edge-detected and turned into single-byte Wishbone cycles
// with a bounded wait for acknowledge and sticky error reporting.
module cpu_wb_bridge #(
    parameter logic [31:0] wb_base = 32'h00000000,
    parameter int unsigned timeout = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_oe,
    input  logic        cpu_nwe,
    input  logic        cpu_noe,
    input  logic        cpu_ncs,
    output logic        cpu_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic        overrun_err
);

    typedef enum logic [1:0] {IDLE, WB_WR, WB_RD} state_t;

    // Last counter value before a cycle is aborted; counter starts at 0 on state entry.
    localparam logic [9:0] TmoLast = 10'(timeout - 1);

    logic       ncs_m, ncs_s, nwe_m, nwe_s, noe_m, noe_s;
    logic       nwe_p, noe_p;
    logic [12:0] addr_q;
    logic [7:0]  data_q;
    logic        wr_evt_q, rd_evt_q;
    logic        wr_evt, rd_evt;
    state_t      state;
    logic [9:0]  cnt;
    logic [7:0]  rd_lane;

    // Two-flop synchronisers plus previous-cycle copies for edge detection; idle is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ncs_m <= 1'b1;
            ncs_s <= 1'b1;
            nwe_m <= 1'b1;
            nwe_s <= 1'b1;
            noe_m <= 1'b1;
            noe_s <= 1'b1;
            nwe_p <= 1'b1;
            noe_p <= 1'b1;
        end else begin
            ncs_m <= cpu_ncs;
            ncs_s <= ncs_m;
            nwe_m <= cpu_nwe;
            nwe_s <= nwe_m;
            noe_m <= cpu_noe;
            noe_s <= noe_m;
            nwe_p <= nwe_s;
            noe_p <= noe_s;
        end
    end

    // Write completes on strobe release; read starts on strobe assertion.
    assign wr_evt = ~ncs_s & nwe_s & ~nwe_p;
    assign rd_evt = ~ncs_s & ~noe_s & noe_p;

    assign cpu_data_oe = ~ncs_s & ~noe_s & nwe_s;

    // Capture address/data while the host strobes are active, and register the events
    // so the FSM sees an address that was sampled while the strobe was still low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= 13'h0;
            data_q   <= 8'h00;
            wr_evt_q <= 1'b0;
            rd_evt_q <= 1'b0;
        end else begin
            if (!ncs_s && (!nwe_s || !noe_s)) addr_q <= cpu_addr;
            if (!ncs_s && !nwe_s) data_q <= cpu_data_i;
            wr_evt_q <= wr_evt;
            rd_evt_q <= rd_evt;
        end
    end

    // Big-endian lane pick for read data, keyed by the one-hot byte select.
    always_comb begin
        rd_lane = 8'h00;
        unique case (wb_sel_o)
            4'b1000: rd_lane = wb_dat_i[31:24];
            4'b0100: rd_lane = wb_dat_i[23:16];
            4'b0010: rd_lane = wb_dat_i[15:8];
            4'b0001: rd_lane = wb_dat_i[7:0];
            default: rd_lane = 8'h00;
        endcase
    end

    // Transaction FSM with registered Wishbone/host outputs and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 10'd0;
            wb_adr_o    <= 32'h0;
            wb_dat_o    <= 32'h0;
            wb_sel_o    <= 4'h0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            cpu_busy    <= 1'b0;
            cpu_data_o  <= 8'h00;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Clear first so a set later in this block takes priority.
            if (err_clr) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= 10'd0;
                    if (wr_evt_q || rd_evt_q) begin
                        wb_adr_o <= wb_base | {19'b0, addr_q};
                        wb_sel_o <= 4'b1000 >> addr_q[1:0];
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        cpu_busy <= 1'b1;
                    end
                    if (wr_evt_q) begin
                        wb_dat_o <= {4{data_q}};
                        wb_we_o  <= 1'b1;
                        state    <= WB_WR;
                        if (rd_evt_q) overrun_err <= 1'b1;
                    end else if (rd_evt_q) begin
                        wb_we_o <= 1'b0;
                        state   <= WB_RD;
                    end
                end
                WB_WR, WB_RD: begin
                    if (wr_evt_q || rd_evt_q) overrun_err <= 1'b1;
                    if (wb_ack_i) begin
                        if (state == WB_RD) cpu_data_o <= rd_lane;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        cpu_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == TmoLast) begin
                        if (state == WB_RD) cpu_data_o <= 8'hFF;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        wb_we_o     <= 1'b0;
                        cpu_busy    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Directed bench for cpu_wb_bridge with a small Wishbone slave model.
module tb_cpu_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_data_i;
    logic [7:0]  cpu_data_o;
    logic        cpu_data_oe;
    logic        cpu_nwe, cpu_noe, cpu_ncs;
    logic        cpu_busy;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        err_clr;
    logic        timeout_err, overrun_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model state
    int          ack_dly = 1;
    int          dly_cnt = 0;
    logic        cyc_p = 1'b0;
    int          n_cyc = 0;
    int          busy_viol = 0;
    logic [31:0] cap_adr = 32'h0, cap_dat = 32'h0;
    logic [3:0]  cap_sel = 4'h0;
    logic        cap_we = 1'b0;

    cpu_wb_bridge #(
        .wb_base (32'h3000_0000),
        .timeout (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_data_oe (cpu_data_oe),
        .cpu_nwe     (cpu_nwe),
        .cpu_noe     (cpu_noe),
        .cpu_ncs     (cpu_ncs),
        .cpu_busy    (cpu_busy),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_ack_i    (wb_ack_i),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // Slave: acks ack_dly cycles after stb (0 = never), and logs each new cycle.
    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (ack_dly != 0 && dly_cnt + 1 >= ack_dly) begin
                wb_ack_i <= 1'b1;
                dly_cnt  <= 0;
            end else begin
                dly_cnt <= dly_cnt + 1;
            end
        end else begin
            wb_ack_i <= 1'b0;
            dly_cnt  <= 0;
        end
        cyc_p <= wb_cyc_o;
        if (wb_cyc_o && !cyc_p) begin
            n_cyc   <= n_cyc + 1;
            cap_adr <= wb_adr_o;
            cap_dat <= wb_dat_o;
            cap_sel <= wb_sel_o;
            cap_we  <= wb_we_o;
        end
        if (wb_cyc_o && !cpu_busy) busy_viol <= busy_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_low(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cpu_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_cyc(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_cyc_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Drive a write strobe low for 4 cycles, returning at the release edge.
    task automatic host_write(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_ncs    = 1'b0;
        cpu_addr   = a;
        cpu_data_i = d;
        cpu_nwe    = 1'b0;
        repeat (4) @(negedge clk);
        cpu_nwe = 1'b1;
    endtask

    task automatic host_read_start(input logic [12:0] a);
        @(negedge clk);
        cpu_ncs  = 1'b0;
        cpu_addr = a;
        cpu_noe  = 1'b0;
    endtask

    task automatic host_idle();
        cpu_noe = 1'b1;
        cpu_nwe = 1'b1;
        cpu_ncs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] exp_b [4];
    int hi_cnt;
    int n0;
    int oe_bad;

    initial begin
        rst        = 1'b0;
        cpu_addr   = 13'h0;
        cpu_data_i = 8'h00;
        cpu_nwe    = 1'b1;
        cpu_noe    = 1'b1;
        cpu_ncs    = 1'b1;
        wb_dat_i   = 32'h0;
        err_clr    = 1'b0;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_data", 32'(cpu_data_o), 32'h00);
        check("rst_oe", 32'(cpu_data_oe), 32'd0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_errs", {30'b0, timeout_err, overrun_err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0xA5 to address 5, slave acks one cycle after stb
        host_write(13'h0005, 8'hA5);
        repeat (3) @(negedge clk);
        check("wr_cyc_early", 32'(wb_cyc_o), 32'd0);
        @(negedge clk);
        check("wr_cyc_4th", 32'(wb_cyc_o), 32'd1);
        check("wr_busy", 32'(cpu_busy), 32'd1);
        check("wr_adr", wb_adr_o, 32'h3000_0005);
        check("wr_sel", 32'(wb_sel_o), 32'h4);
        check("wr_dat", wb_dat_o, 32'hA5A5_A5A5);
        check("wr_we", 32'(wb_we_o), 32'd1);
        @(negedge clk);
        check("wr_busy_ack", 32'(cpu_busy), 32'd1);
        @(negedge clk);
        check("wr_done_busy", 32'(cpu_busy), 32'd0);
        check("wr_done_cyc", 32'(wb_cyc_o), 32'd0);
        check("wr_ncyc", 32'(n_cyc), 32'd1);
        check("wr_busy_thru", 32'(busy_viol), 32'd0);
        check("wr_errs", {30'b0, timeout_err, overrun_err}, 32'd0);
        host_idle();

        // Reads of each byte lane from 0x11223344
        wb_dat_i = 32'h1122_3344;
        for (int a = 3; a >= 0; a--) begin
            host_read_start(13'(a));
            repeat (5) @(negedge clk);
            check("rd_busy", 32'(cpu_busy), 32'd1);
            check("rd_oe", 32'(cpu_data_oe), 32'd1);
            check("rd_sel", 32'(cap_sel), 32'(4'b1000 >> a));
            check("rd_we", 32'(cap_we), 32'd0);
            @(negedge clk);
            check("rd_busy_fall", 32'(cpu_busy), 32'd0);
            check("rd_data", 32'(cpu_data_o), 32'(exp_b[a]));
            host_idle();
        end
        check("rd_ncyc", 32'(n_cyc), 32'd5);

        // Non-acking slave: abort after 8 cycles
        ack_dly = 0;
        host_read_start(13'h0010);
        wait_cyc("tmo_cyc_start");
        hi_cnt = 1;
        repeat (20) begin
            @(negedge clk);
            if (wb_cyc_o) hi_cnt++;
        end
        check("tmo_len", 32'(hi_cnt), 32'd8);
        check("tmo_data", 32'(cpu_data_o), 32'hFF);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_busy", 32'(cpu_busy), 32'd0);
        check("tmo_ovr", 32'(overrun_err), 32'd0);
        host_idle();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_clr", 32'(timeout_err), 32'd0);

        // Second write while the first waits; ack lands on the timeout limit cycle
        ack_dly = 7;
        n0 = n_cyc;
        host_write(13'h0102, 8'h3C);
        wait_cyc("ovr_cyc_start");
        cpu_nwe    = 1'b0;
        cpu_data_i = 8'h5A;
        repeat (2) @(negedge clk);
        cpu_nwe = 1'b1;
        wait_busy_low("ovr_done");
        repeat (6) @(negedge clk);
        check("ovr_ncyc", 32'(n_cyc - n0), 32'd1);
        check("ovr_dat", cap_dat, 32'h3C3C_3C3C);
        check("ovr_sel", 32'(cap_sel), 32'h2);
        check("ovr_err", 32'(overrun_err), 32'd1);
        check("ovr_ack_wins", 32'(timeout_err), 32'd0);
        host_idle();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr_clr", 32'(overrun_err), 32'd0);

        // Asynchronous reset mid-cycle
        ack_dly = 0;
        host_read_start(13'h0001);
        wait_cyc("arst_cyc_start");
        #2 rst = 1'b0;
        #1;
        check("arst_cyc", 32'(wb_cyc_o), 32'd0);
        check("arst_stb", 32'(wb_stb_o), 32'd0);
        check("arst_busy", 32'(cpu_busy), 32'd0);
        cpu_noe = 1'b1;
        cpu_ncs = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        ack_dly = 1;
        repeat (2) @(negedge clk);
        host_read_start(13'h0001);
        wait_busy_low("arst_rd_done");
        repeat (5) @(negedge clk);
        check("arst_rd_data", 32'(cpu_data_o), 32'h22);
        check("arst_rd_busy", 32'(cpu_busy), 32'd0);
        host_idle();

        // Strobes toggled with chip select high
        n0 = n_cyc;
        oe_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_nwe = i[0];
            cpu_noe = ~i[1];
            if (cpu_data_oe) oe_bad++;
        end
        cpu_nwe = 1'b1;
        cpu_noe = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (cpu_data_oe) oe_bad++;
        end
        check("ncs_no_cyc", 32'(n_cyc - n0), 32'd0);
        check("ncs_oe", 32'(oe_bad), 32'd0);
        check("ncs_errs", {30'b0, timeout_err, overrun_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_wb_bridge.md
Name: cpu_wb_bridge

Overview:
- Bridges the external host CPU's asynchronous SRAM-style bus onto the SoC Wishbone bus as an initiator.
- Connects to the external pins (13-bit address, 8-bit data, active-low nwe/noe/ncs) and to a spare master port of the Wishbone interconnect.
- Lets the host read and write any Wishbone slave (bram, uart, timer, gpio) one byte at a time.
- Provides a busy/wait indication to the host, a bus timeout and sticky error flags.

Parameters:
- wb_base, 32'h00000000, constant ORed onto the zero-extended host address to form wb_adr_o.
- timeout, 255, number of clk cycles a Wishbone cycle may wait for wb_ack_i before it is aborted (range 1..1023).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cpu_addr  in  13  host byte address.
- cpu_data_i  in  8  host write data.
- cpu_data_o  out  8  host read data.
- cpu_data_oe  out  1  enable for the host data pad driver.
- cpu_nwe  in  1  host write strobe, active-low.
- cpu_noe  in  1  host read strobe, active-low.
- cpu_ncs  in  1  host chip select, active-low.
- cpu_busy  out  1  high while a host access is in flight on Wishbone.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte lane select.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- err_clr  in  1  single-cycle pulse; clears both error flags.
- timeout_err  out  1  sticky flag: a Wishbone cycle timed out.
- overrun_err  out  1  sticky flag: a host strobe arrived while busy.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0, except cpu_data_o = 8'h00.
  - Synchronizers are set to 1 (pins treated as idle).
  - FSM goes to IDLE; timeout counter is 0.
- Synchronisation:
  - cpu_ncs, cpu_nwe and cpu_noe each pass through 2 flops; the synchronized values are ncs_s, nwe_s, noe_s.
  - Previous-cycle copies of nwe_s and noe_s are used for edge detection.
- Capture:
  - cpu_addr and cpu_data_i are registered every cycle in which ncs_s=0 and nwe_s=0 (or noe_s=0 for address).
  - The host must hold address and data stable for at least 3 clk periods before releasing the strobe.
- Write event: rising edge of nwe_s while ncs_s=0. The access completes on the host's release of nwe.
- Read event: falling edge of noe_s while ncs_s=0.
- Address mapping:
  - wb_adr_o = wb_base | {19'b0, addr}.
  - Big-endian lanes: addr[1:0]=0 gives sel 4'b1000, 1 gives 4'b0100, 2 gives 4'b0010, 3 gives 4'b0001.
  - wb_dat_o = {4{data}} on writes.
- FSM states:
  - IDLE: on a write event, load adr/sel/dat, set we=1, cyc=stb=1 and go to WB_WR. On a read event, load adr/sel, set we=0, cyc=stb=1 and go to WB_RD. cpu_busy=1 from the event cycle onward.
  - WB_WR: on wb_ack_i, drop cyc/stb/we and cpu_busy and return to IDLE.
  - WB_RD: on wb_ack_i, cpu_data_o <= selected lane of wb_dat_i (addr[1:0]=0 gives [31:24] … 3 gives [7:0]); drop cyc/stb and cpu_busy the same edge; return to IDLE.
- Latency:
  - A pin edge meeting setup causes cyc/stb to assert on the 4th rising clk edge.
  - With a zero-wait slave (ack the cycle after stb), read data is on cpu_data_o 2 cycles after stb.
- Timeout:
  - The counter increments every cycle in WB_WR/WB_RD and is cleared on state entry.
  - When it reaches timeout without an ack: drop cyc/stb; on a read, cpu_data_o <= 8'hFF; set timeout_err; return to IDLE.
  - An ack arriving in the same cycle as the limit wins (normal completion).
- Overrun: a write or read event while not in IDLE is dropped and sets overrun_err. The transaction in progress is unaffected.
- Error flags:
  - Both flags are sticky and cleared only by err_clr or reset.
  - If a set condition and err_clr occur in the same cycle, set wins.
- cpu_data_oe = ~ncs_s & ~noe_s & ~nwe_s_n… specifically, it is 1 when ncs_s=0 and noe_s=0 and nwe_s=1; otherwise 0.
- Simultaneous write and read events in IDLE: the write wins, and the read counts as an overrun.
- Reset mid-cycle drops cyc/stb immediately (asynchronously); there is no retry.

Test Plan:
- Host write, addr 13'h0005, data 8'hA5, slave acks after 1 cycle:
  - Required: a single Wishbone cycle with adr=wb_base|5, sel=4'b0100, dat=32'hA5A5A5A5, we=1.
  - Required: cpu_busy high throughout, then low; no error flags set.
- Host read, addr 13'h0003, slave returns 32'h11223344:
  - Required: cpu_data_o=8'h44 and cpu_busy falls in the same cycle.
  - Required: repeated for addr 0/1/2, returning 8'h11/8'h22/8'h33.
- Read to a non-acking slave with timeout=8:
  - Required: cyc/stb drop after exactly 8 cycles, cpu_data_o=8'hFF, timeout_err=1.
  - Required: err_clr pulse gives timeout_err=0.
- Second nwe pulse issued while the first write is still waiting for ack:
  - Required: only one Wishbone cycle, overrun_err=1.
- Assert rst low while stb=1:
  - Required: cyc/stb/cpu_busy go to 0 without waiting for a clock.
  - Required: after release, a new read completes normally.
- Strobe toggled with ncs=1:
  - Required: no Wishbone activity and cpu_data_oe stays 0.
